// File: rtl/soc_pio_pkg.sv
// Shared definitions for the pulse-capable output PIO: register word
// addresses and the pulse timer state encoding.
package soc_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_LEN    = 3'd1;
    localparam logic [2:0] ADDR_SET    = 3'd2;
    localparam logic [2:0] ADDR_CLEAR  = 3'd3;
    localparam logic [2:0] ADDR_PULSE  = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } pulse_state_t;

endpackage

// File: rtl/soc_pio_pulse_timer.sv
// Pulse timer: a LEN_WIDTH-bit down-counter with a two-state FSM.
// load starts or restarts a pulse of len+1 cycles; stop forces IDLE
// (load has priority). expire is high during the last pulse cycle.
module soc_pio_pulse_timer
    import soc_pio_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 stop,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 expire
);

    pulse_state_t         state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;

    // State and counter registers; reset aborts any pulse at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments for all clocked state so every
            // register samples the pre-edge values of the others.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: load restarts, stop idles, otherwise count down to expiry.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = ST_PULSE;
            cnt_d   = len;
        end else if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_PULSE) begin
            if (cnt_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - LEN_WIDTH'(1);
            end
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy   = (state_q == ST_PULSE);
        expire = (state_q == ST_PULSE) && (cnt_q == '0);
    end

endmodule

// File: rtl/soc_system_pio_pulse_out.sv
// Avalon-MM output PIO with SET/CLEAR access and optional hardware-timed
// pulses. Zero wait states, read latency 0.
// Define SOC_PIO_PULSE_EN to build PULSE_LEN, PULSE, STATUS and the timer.
module soc_system_pio_pulse_out
    import soc_pio_pkg::*;
#(
    parameter int                   WIDTH       = 8,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
    parameter int                   LEN_WIDTH   = 16,
    parameter logic [LEN_WIDTH-1:0] LEN_RESET   = LEN_WIDTH'(15)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q, data_d;
    logic             unused_writedata;

    assign wr_en            = chipselect && !write_n;
    assign wd               = writedata[WIDTH-1:0];
    assign unused_writedata = ^writedata;
    assign out_port         = data_q;

`ifdef SOC_PIO_PULSE_EN
    logic [LEN_WIDTH-1:0] len_q;
    logic [WIDTH-1:0]     mask_q, mask_d;
    logic                 pulse_load, timer_stop, busy, expire;

    // A zero pulse write is ignored; a DATA write or an emptied mask idles.
    assign pulse_load = wr_en && (address == ADDR_PULSE) && (wd != '0);
    assign timer_stop = (wr_en && (address == ADDR_DATA)) ||
                        (busy && (mask_q == '0));

    soc_pio_pulse_timer #(
        .LEN_WIDTH(LEN_WIDTH)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (pulse_load),
        .stop   (timer_stop),
        .len    (len_q),
        .busy   (busy),
        .expire (expire)
    );

    // PULSE_LEN register; only later triggers see a new value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q <= LEN_RESET;
        end else if (wr_en && (address == ADDR_LEN)) begin
            len_q <= writedata[LEN_WIDTH-1:0];
        end
    end

    // Pulse mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end
`endif

    // Output data register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    // Update: expiry clear first, then the bus access layered on top of it.
    always_comb begin
        data_d = data_q;
`ifdef SOC_PIO_PULSE_EN
        mask_d = mask_q;
        if (expire) begin
            data_d = data_q & ~mask_q;
            mask_d = '0;
        end
`endif
        if (wr_en) begin
            case (address)
                ADDR_DATA: begin
                    data_d = wd;
`ifdef SOC_PIO_PULSE_EN
                    mask_d = '0;
`endif
                end
                ADDR_SET:   data_d = data_d | wd;
                ADDR_CLEAR: begin
                    data_d = data_d & ~wd;
`ifdef SOC_PIO_PULSE_EN
                    mask_d = mask_d & ~wd;
`endif
                end
`ifdef SOC_PIO_PULSE_EN
                ADDR_PULSE: begin
                    if (wd != '0) begin
                        data_d = data_d | wd;
                        mask_d = mask_d | wd;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Combinational, zero-extended read mux.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[WIDTH-1:0] = data_q;
`ifdef SOC_PIO_PULSE_EN
            ADDR_LEN:    readdata[LEN_WIDTH-1:0] = len_q;
            ADDR_PULSE:  readdata[WIDTH-1:0] = mask_q;
            ADDR_STATUS: readdata[0] = busy;
`endif
            default: ;
        endcase
    end

endmodule

// File: doc/soc_system_pio_pulse_out.md
# soc_system_pio_pulse_out

Parametrised Avalon-MM output PIO that replaces fixed single-bit output ports such as the chaos-reset strobe. It drives a WIDTH-bit `out_port` and adds atomic SET/CLEAR access and a hardware-timed pulse mode. In pulse mode, selected bits assert for a programmable number of clocks and then self-clear, so software never has to time reset or strobe pulses. It sits on the HPS lightweight bridge as a zero-wait-state, read-latency-0 slave.

## Interface
Parameters:
- WIDTH, 8: output port width, legal range 1..32.
- RESET_VALUE, 0: value of `out_port` after reset (WIDTH bits).
- LEN_WIDTH, 16: width of the PULSE_LEN register and the pulse counter, legal range 1..32.
- LEN_RESET, 15: reset value of PULSE_LEN.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write is accepted when chipselect && !write_n.
- writedata  in  32  write data; bits above WIDTH (or above LEN_WIDTH for PULSE_LEN) are ignored.
- readdata  out  32  combinational read mux, zero-extended.
- out_port  out  WIDTH  registered output.

## Operation
Register map (word addresses):
- 0 DATA, RW: write sets data_out = wd, clears pulse_mask and returns the FSM to IDLE. Read returns data_out.
- 1 PULSE_LEN, RW: LEN_WIDTH-bit value L.
- 2 SET, WO: data_out |= wd. Reads 0.
- 3 CLEAR, WO: data_out &= ~wd and pulse_mask &= ~wd. Reads 0.
- 4 PULSE, WO: triggers a pulse on bits wd. Read returns pulse_mask.
- 5 STATUS, RO: bit0 = busy (FSM in PULSE state).
- 6, 7: reserved. Writes are ignored; reads return 0.

Pulse FSM:
- IDLE → PULSE on a PULSE write with wd[WIDTH-1:0] != 0:
  - data_out |= wd
  - pulse_mask = wd
  - cnt = L
- PULSE write with wd == 0 is ignored.
- In PULSE, each cycle:
  - if cnt != 0, cnt decrements;
  - if cnt == 0 (expiry), data_out &= ~pulse_mask, pulse_mask = 0, next state IDLE.
- PULSE write while busy (retrigger):
  - pulse_mask |= wd
  - data_out |= wd
  - cnt = L
- pulse_mask becoming 0 through CLEAR forces IDLE on the next edge.
- PULSE_LEN writes affect only subsequent triggers and retriggers.

Simultaneous events (one bus access per cycle, coinciding with expiry):
- DATA write wins entirely.
- SET: expiry clear is applied first, then the SET OR, so SET bits end high.
- CLEAR: both clears apply.
- PULSE write: old mask bits not in wd are cleared, pulse_mask = wd, cnt = L, state stays PULSE.

Reset:
- data_out = RESET_VALUE, PULSE_LEN = LEN_RESET, pulse_mask = 0, cnt = 0, state IDLE.
- out_port therefore resets to RESET_VALUE.
- Assertion mid-pulse aborts the pulse immediately (asynchronous).

## Timing
- Read latency 0: readdata is combinational from address and register state.
- Writes take effect at the accepting clock edge; out_port changes on that same edge.
- Pulse timing for a PULSE write accepted at edge k:
  - bits are high from edge k;
  - bits clear at edge k+L+1, giving L+1 cycles high;
  - L = 0 gives a 1-cycle pulse.
- STATUS.busy is high for exactly the same L+1 cycles.
- A retrigger at edge j extends the pulse end to edge j+L+1.

## Configuration
- Macro `SOC_PIO_PULSE_EN`, when defined: the pulse FSM, counter, PULSE_LEN register and pulse_mask are built as described above.
- When not defined:
  - addresses 1, 4 and 5 ignore writes and read 0;
  - no counter or FSM is synthesised;
  - DATA, SET and CLEAR behave identically, except that CLEAR has no mask effect.

## Structure
- Package `soc_pio_pkg` holds:
  - address constants ADDR_DATA..ADDR_STATUS;
  - FSM state enum {ST_IDLE, ST_PULSE}.
- Sub-module `soc_pio_pulse_timer` holds the LEN_WIDTH-bit down-counter and FSM.
  - Inputs: load, len.
  - Outputs: busy, expire.
  - It is instantiated only under `SOC_PIO_PULSE_EN`.
- The top level owns the register file, data_out/pulse_mask update logic and the read mux.

## Test plan
- Reset with RESET_VALUE=8'hA5 → out_port=8'hA5; PULSE_LEN reads 15; STATUS=0. SET 8'h0A then CLEAR 8'h05 → 8'hAF then 8'hAA.
- PULSE_LEN=3, DATA=0, PULSE 8'h01 at edge k → bit0 high for exactly 4 cycles and low at edge k+4; busy tracks it.
- PULSE_LEN=0, PULSE 8'h80 → 1-cycle pulse. PULSE with wd=0 → no change, busy stays 0.
- PULSE_LEN=5, PULSE 8'h01, then PULSE 8'h02 at k+3 → both bits high until k+9, then both low; pulse_mask reads 8'h03 at k+4.
- SET 8'h01 coinciding with expiry of a bit0 pulse → bit0 stays high. DATA write mid-pulse → out_port = written value; busy=0 next cycle.
- reset_n asserted asynchronously mid-pulse → out_port=RESET_VALUE immediately; busy=0. With the macro undefined, a PULSE write → out_port unchanged and address 4 reads 0.
